// File: rtl/butterfly_radix4_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_radix4_pipe
//
// Three-stage pipelined radix-4 DIT butterfly with per-sample forward/inverse
// selection, output scaling with round-half-up, and saturating outputs.
//
//   S1 : twiddle multiplies m0 = b*w0, m1 = c*w1, m2 = d*w2 (rounded Q1.x)
//   S2 : t0 = a+m1, t1 = a-m1, t2 = m0+m2, t3 = m0-m2
//   S3 : combine, optional >>1 / >>2 with rounding, saturate to DATA_W
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready == pipeline advance)
//   ar..di                four complex input samples (signed DATA_W)
//   w0r..w2i              twiddles for b, c, d (signed Q1.(TW_W-1))
//   inv                   0 = forward, 1 = inverse (travels with sample)
//   scale                 output right shift 0/1/2, 3 behaves as 2
//   clr_ovf               clears the sticky overflow flag
//   out_valid / out_ready output handshake
//   out0r..out3i          four complex results (registered)
//   ovf                   sticky saturation flag (registered)
// -----------------------------------------------------------------------------
module butterfly_radix4_pipe #(
    parameter int DATA_W  = 32,
    parameter int TW_W    = 16,
    parameter int GUARD_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] ar,
    input  logic signed [DATA_W-1:0] ai,
    input  logic signed [DATA_W-1:0] br,
    input  logic signed [DATA_W-1:0] bi,
    input  logic signed [DATA_W-1:0] cr,
    input  logic signed [DATA_W-1:0] ci,
    input  logic signed [DATA_W-1:0] dr,
    input  logic signed [DATA_W-1:0] di,
    input  logic signed [TW_W-1:0]   w0r,
    input  logic signed [TW_W-1:0]   w0i,
    input  logic signed [TW_W-1:0]   w1r,
    input  logic signed [TW_W-1:0]   w1i,
    input  logic signed [TW_W-1:0]   w2r,
    input  logic signed [TW_W-1:0]   w2i,
    input  logic                     inv,
    input  logic [1:0]               scale,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out0r,
    output logic signed [DATA_W-1:0] out0i,
    output logic signed [DATA_W-1:0] out1r,
    output logic signed [DATA_W-1:0] out1i,
    output logic signed [DATA_W-1:0] out2r,
    output logic signed [DATA_W-1:0] out2i,
    output logic signed [DATA_W-1:0] out3r,
    output logic signed [DATA_W-1:0] out3i,
    output logic                     ovf
);

    // Full complex product width: the sum of two DATA_W x TW_W products.
    localparam int PW  = DATA_W + TW_W + 1;
    // Width left after removing TW_W-1 fraction bits from a full product.
    localparam int MW  = PW - (TW_W - 1);
    // Add-tree width for the t-terms, and one more bit for the final combine.
    localparam int T2W = DATA_W + GUARD_W;
    localparam int S3W = T2W + 1;

    localparam logic signed [PW-1:0]  RND_PROD = {{(PW-1){1'b0}}, 1'b1} << (TW_W - 2);
    localparam logic signed [S3W-1:0] RND_S1   = {{(S3W-1){1'b0}}, 1'b1};
    localparam logic signed [S3W-1:0] RND_S2   = {{(S3W-2){1'b0}}, 2'b10};
    localparam logic signed [S3W-1:0] SAT_MAX  = {{(S3W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [S3W-1:0] SAT_MIN  = {{(S3W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Round a full-precision product back to the data scale (half-up).
    function automatic logic signed [MW-1:0] round_prod(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + RND_PROD) >>> (TW_W - 1);
        return MW'(r);
    endfunction

    // Arithmetic right shift by 0/1/2 with round-half-up; 3 acts as 2.
    function automatic logic signed [S3W-1:0] scale_round(input logic signed [S3W-1:0] x,
                                                          input logic [1:0] s);
        logic signed [S3W-1:0] y;
        case (s)
            2'd0:    y = x;
            2'd1:    y = (x + RND_S1) >>> 1;
            default: y = (x + RND_S2) >>> 2;
        endcase
        return y;
    endfunction

    // Clamp to DATA_W; MSB of the result flags that clamping happened.
    function automatic logic [DATA_W:0] saturate(input logic signed [S3W-1:0] x);
        logic [DATA_W:0] r;
        if (x > SAT_MAX) begin
            r = {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (x < SAT_MIN) begin
            r = {1'b1, SAT_MIN[DATA_W-1:0]};
        end else begin
            r = {1'b0, x[DATA_W-1:0]};
        end
        return r;
    endfunction

    logic adv_s;

    // Stage 1 registers
    logic                     s1_valid_r;
    logic signed [DATA_W-1:0] s1_ar_r, s1_ai_r;
    logic signed [MW-1:0]     s1_m0r_r, s1_m0i_r, s1_m1r_r, s1_m1i_r, s1_m2r_r, s1_m2i_r;
    logic                     s1_inv_r;
    logic [1:0]               s1_scale_r;

    // Stage 2 registers
    logic                     s2_valid_r;
    logic signed [T2W-1:0]    s2_t0r_r, s2_t0i_r, s2_t1r_r, s2_t1i_r;
    logic signed [T2W-1:0]    s2_t2r_r, s2_t2i_r, s2_t3r_r, s2_t3i_r;
    logic                     s2_inv_r;
    logic [1:0]               s2_scale_r;

    // Combinational stage results
    logic signed [MW-1:0]     m0r_s, m0i_s, m1r_s, m1i_s, m2r_s, m2i_s;
    logic signed [T2W-1:0]    t0r_s, t0i_s, t1r_s, t1i_s, t2r_s, t2i_s, t3r_s, t3i_s;
    logic signed [S3W-1:0]    raw_s [8];
    logic signed [S3W-1:0]    x1r_s, x1i_s, x3r_s, x3i_s;
    logic [DATA_W:0]          sat_s [8];
    logic                     any_sat_s;

    // The whole pipe moves only when the output slot is empty or being taken.
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    // S1 complex multiplies: (xr + j xi)(wr + j wi) at full precision.
    always_comb begin
        m0r_s = round_prod(PW'(br) * PW'(w0r) - PW'(bi) * PW'(w0i));
        m0i_s = round_prod(PW'(br) * PW'(w0i) + PW'(bi) * PW'(w0r));
        m1r_s = round_prod(PW'(cr) * PW'(w1r) - PW'(ci) * PW'(w1i));
        m1i_s = round_prod(PW'(cr) * PW'(w1i) + PW'(ci) * PW'(w1r));
        m2r_s = round_prod(PW'(dr) * PW'(w2r) - PW'(di) * PW'(w2i));
        m2i_s = round_prod(PW'(dr) * PW'(w2i) + PW'(di) * PW'(w2r));
    end

    // S2 t-terms, sign-extended into the guarded add-tree width.
    always_comb begin
        t0r_s = T2W'(s1_ar_r) + T2W'(s1_m1r_r);
        t0i_s = T2W'(s1_ai_r) + T2W'(s1_m1i_r);
        t1r_s = T2W'(s1_ar_r) - T2W'(s1_m1r_r);
        t1i_s = T2W'(s1_ai_r) - T2W'(s1_m1i_r);
        t2r_s = T2W'(s1_m0r_r) + T2W'(s1_m2r_r);
        t2i_s = T2W'(s1_m0i_r) + T2W'(s1_m2i_r);
        t3r_s = T2W'(s1_m0r_r) - T2W'(s1_m2r_r);
        t3i_s = T2W'(s1_m0i_r) - T2W'(s1_m2i_r);
    end

    // S3 combine; the inverse transform just swaps the +/-j outputs.
    always_comb begin
        x1r_s    = S3W'(s2_t1r_r) + S3W'(s2_t3i_r);
        x1i_s    = S3W'(s2_t1i_r) - S3W'(s2_t3r_r);
        x3r_s    = S3W'(s2_t1r_r) - S3W'(s2_t3i_r);
        x3i_s    = S3W'(s2_t1i_r) + S3W'(s2_t3r_r);
        raw_s[0] = S3W'(s2_t0r_r) + S3W'(s2_t2r_r);
        raw_s[1] = S3W'(s2_t0i_r) + S3W'(s2_t2i_r);
        raw_s[4] = S3W'(s2_t0r_r) - S3W'(s2_t2r_r);
        raw_s[5] = S3W'(s2_t0i_r) - S3W'(s2_t2i_r);
        if (s2_inv_r) begin
            raw_s[2] = x3r_s;
            raw_s[3] = x3i_s;
            raw_s[6] = x1r_s;
            raw_s[7] = x1i_s;
        end else begin
            raw_s[2] = x1r_s;
            raw_s[3] = x1i_s;
            raw_s[6] = x3r_s;
            raw_s[7] = x3i_s;
        end
        any_sat_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sat_s[i]  = saturate(scale_round(raw_s[i], s2_scale_r));
            any_sat_s = any_sat_s | sat_s[i][DATA_W];
        end
    end

    // Stage 1 register: capture inputs and rounded products.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_ar_r    <= '0;
            s1_ai_r    <= '0;
            s1_m0r_r   <= '0;
            s1_m0i_r   <= '0;
            s1_m1r_r   <= '0;
            s1_m1i_r   <= '0;
            s1_m2r_r   <= '0;
            s1_m2i_r   <= '0;
            s1_inv_r   <= 1'b0;
            s1_scale_r <= 2'd0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_ar_r    <= ar;
                s1_ai_r    <= ai;
                s1_m0r_r   <= m0r_s;
                s1_m0i_r   <= m0i_s;
                s1_m1r_r   <= m1r_s;
                s1_m1i_r   <= m1i_s;
                s1_m2r_r   <= m2r_s;
                s1_m2i_r   <= m2i_s;
                s1_inv_r   <= inv;
                s1_scale_r <= scale;
            end
        end
    end

    // Stage 2 register: capture t-terms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_t0r_r   <= '0;
            s2_t0i_r   <= '0;
            s2_t1r_r   <= '0;
            s2_t1i_r   <= '0;
            s2_t2r_r   <= '0;
            s2_t2i_r   <= '0;
            s2_t3r_r   <= '0;
            s2_t3i_r   <= '0;
            s2_inv_r   <= 1'b0;
            s2_scale_r <= 2'd0;
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_t0r_r   <= t0r_s;
                s2_t0i_r   <= t0i_s;
                s2_t1r_r   <= t1r_s;
                s2_t1i_r   <= t1i_s;
                s2_t2r_r   <= t2r_s;
                s2_t2i_r   <= t2i_s;
                s2_t3r_r   <= t3r_s;
                s2_t3i_r   <= t3i_s;
                s2_inv_r   <= s1_inv_r;
                s2_scale_r <= s1_scale_r;
            end
        end
    end

    // Output register and sticky overflow; a new saturation beats a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out0r     <= '0;
            out0i     <= '0;
            out1r     <= '0;
            out1i     <= '0;
            out2r     <= '0;
            out2i     <= '0;
            out3r     <= '0;
            out3i     <= '0;
            ovf       <= 1'b0;
        end else if (adv_s) begin
            out_valid <= s2_valid_r;
            if (s2_valid_r) begin
                out0r <= sat_s[0][DATA_W-1:0];
                out0i <= sat_s[1][DATA_W-1:0];
                out1r <= sat_s[2][DATA_W-1:0];
                out1i <= sat_s[3][DATA_W-1:0];
                out2r <= sat_s[4][DATA_W-1:0];
                out2i <= sat_s[5][DATA_W-1:0];
                out3r <= sat_s[6][DATA_W-1:0];
                out3i <= sat_s[7][DATA_W-1:0];
            end
            if (s2_valid_r && any_sat_s) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_butterfly_radix4_pipe.sv
// -----------------------------------------------------------------------------
// tb_butterfly_radix4_pipe
//
// Directed-vector bench with a scoreboard: each accepted input pushes its
// hand-computed result into a queue; a negedge monitor pops and compares
// whenever the DUT hands off an output.
// -----------------------------------------------------------------------------
module tb_butterfly_radix4_pipe;

    typedef struct packed {
        logic [7:0][31:0] v;
        int               cyc;
        logic             lat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n, in_valid, in_ready, inv, clr_ovf, out_valid, out_ready, ovf;
    logic signed [31:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [15:0] w0r, w0i, w1r, w1i, w2r, w2i;
    logic [1:0]         scale;
    logic signed [31:0] out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t sb[$];

    butterfly_radix4_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
        .w0r(w0r), .w0i(w0i), .w1r(w1r), .w1i(w1i), .w2r(w2r), .w2i(w2i),
        .inv(inv), .scale(scale), .clr_ovf(clr_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0r(out0r), .out0i(out0i), .out1r(out1r), .out1i(out1i),
        .out2r(out2r), .out2i(out2i), .out3r(out3r), .out3i(out3i),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0][31:0] mk(input int o0r, o0i, o1r, o1i, o2r, o2i, o3r, o3i);
        logic [7:0][31:0] r;
        r[0] = 32'(o0r); r[1] = 32'(o0i); r[2] = 32'(o1r); r[3] = 32'(o1i);
        r[4] = 32'(o2r); r[5] = 32'(o2i); r[6] = 32'(o3r); r[7] = 32'(o3i);
        return r;
    endfunction

    function automatic logic [255:0] outs();
        return {out3i, out3r, out2i, out2r, out1i, out1r, out0i, out0r};
    endfunction

    // All three twiddles get the same value; tests that need distinct ones keep c/d at zero.
    task automatic set_in(input int a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i,
                          input int w_r, w_i, input logic iv, input logic [1:0] sc);
        ar = 32'(a_r); ai = 32'(a_i); br = 32'(b_r); bi = 32'(b_i);
        cr = 32'(c_r); ci = 32'(c_i); dr = 32'(d_r); di = 32'(d_i);
        w0r = 16'(w_r); w0i = 16'(w_i); w1r = 16'(w_r); w1i = 16'(w_i);
        w2r = 16'(w_r); w2i = 16'(w_i);
        inv = iv; scale = sc;
    endtask

    // Present the current inputs until accepted, then log the expected result.
    task automatic issue(input logic [7:0][31:0] e, input logic lat);
        int   g = 0;
        exp_t x;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (in_ready) begin
            x.v = e; x.cyc = cyc; x.lat = lat;
            sb.push_back(x);
        end else begin
            chk("accept_timeout", 256'(in_ready), 256'(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 256'(sb.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected none", outs());
            end else begin
                e = sb.pop_front();
                chk("out_data", outs(), e.v);
                if (e.lat) chk("latency", 256'(cyc - e.cyc), 256'(3));
            end
        end
    end

    initial begin
        logic [255:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_ovf", 256'(ovf), 256'(0));
        chk("reset_data", outs(), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 256'(in_ready), 256'(1));
        @(posedge clk); #1;

        // a only: every output equals a regardless of twiddles
        set_in(100, 0, 0, 0, 0, 0, 0, 0, 12345, -777, 1'b0, 2'd0);
        issue(mk(100, 0, 100, 0, 100, 0, 100, 0), 1'b1);
        drain();
        chk("ovf_clean", 256'(ovf), 256'(0));

        // all equal inputs, unity twiddles, scales 0/1/2/3 back to back
        set_in(1000, 0, 1000, 0, 1000, 0, 1000, 0, 32767, 0, 1'b0, 2'd0);
        issue(mk(4000, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        scale = 2'd2;
        issue(mk(1000, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        scale = 2'd1;
        issue(mk(2000, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        scale = 2'd3;
        issue(mk(1000, 0, 0, 0, 0, 0, 0, 0), 1'b1);

        // b only: forward then inverse
        set_in(0, 0, 1000, 0, 0, 0, 0, 0, 32767, 0, 1'b0, 2'd0);
        issue(mk(1000, 0, 0, -1000, -1000, 0, 0, 1000), 1'b1);
        inv = 1'b1;
        issue(mk(1000, 0, 0, 1000, -1000, 0, 0, -1000), 1'b1);

        // rounding half-up on negative and positive values
        set_in(3, -3, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd1);
        issue(mk(2, -1, 2, -1, 2, -1, 2, -1), 1'b1);
        set_in(-6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd2);
        issue(mk(-1, 2, -1, 2, -1, 2, -1, 2), 1'b1);

        // twiddle of -1.0 with complex b: m0 = (-1000, 500)
        set_in(0, 0, 1000, -500, 0, 0, 0, 0, -32768, 0, 1'b0, 2'd0);
        issue(mk(-1000, 500, 500, 1000, 1000, -500, -500, -1000), 1'b1);
        drain();
        chk("ovf_no_sat", 256'(ovf), 256'(0));

        // full-scale inputs saturate out0r and set the sticky flag
        set_in(32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0,
               32767, 0, 1'b0, 2'd0);
        issue(mk(32'h7FFFFFFF, 0, 65536, 0, 65536, 0, 65536, 0), 1'b1);
        drain();
        chk("ovf_set", 256'(ovf), 256'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_sticky", 256'(ovf), 256'(1));
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("ovf_cleared", 256'(ovf), 256'(0));

        // (-2^31) * (-1.0) = +2^31 must survive S1 and then saturate
        set_in(0, 0, 32'h80000000, 0, 0, 0, 0, 0, -32768, 0, 1'b0, 2'd0);
        issue(mk(32'h7FFFFFFF, 0, 0, 32'h80000000, 32'h80000000, 0, 0, 32'h7FFFFFFF), 1'b1);
        drain();
        chk("ovf_min_twiddle", 256'(ovf), 256'(1));
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;

        // stream of 6 with a 4-cycle output stall
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    set_in(k * 111, -k * 7, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
                    issue(mk(k * 111, -k * 7, k * 111, -k * 7, k * 111, -k * 7, k * 111, -k * 7), 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = outs();
                chk("stall_in_ready", 256'(in_ready), 256'(0));
                chk("stall_out_valid", 256'(out_valid), 256'(1));
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 256'(in_ready), 256'(0));
                    chk("stall_hold", outs(), held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with three samples in flight discards them
        for (int k = 1; k <= 3; k++) begin
            set_in(500 + k, k, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
            issue(mk(500 + k, k, 500 + k, k, 500 + k, k, 500 + k, k), 1'b1);
        end
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_out_valid", 256'(out_valid), 256'(0));
        repeat (8) @(posedge clk);
        #1;
        chk("no_stale_output", 256'(out_valid), 256'(0));

        // pipeline still works after the flush
        set_in(77, -5, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
        issue(mk(77, -5, 77, -5, 77, -5, 77, -5), 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
